// File: rtl/lab_1_rr_arbiter.sv
// Round-robin arbiter and sequencer for the shared 2-bit 4:1 select datapath.
// Grants one requester at a time for a bounded burst of handshaked beats.
//
//   state    | meaning
//   ---------+------------------------------------------------------------
//   ST_IDLE  | no owner, grant=0000, {s1,s0} holds its last value
//   ST_GRANT | owner granted, beats counted on valid & ready
module lab_1_rr_arbiter #(
  parameter int unsigned BEAT_MAX = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [3:0] req,
  input  logic [1:0] a,
  input  logic [1:0] b,
  input  logic [1:0] c,
  input  logic [1:0] d,
  input  logic       ready,
  output logic [3:0] grant,
  output logic       s1,
  output logic       s0,
  output logic       valid,
  output logic [1:0] y
);

  typedef enum logic {ST_IDLE, ST_GRANT} state_t;

  localparam logic [3:0] BEAT_LAST = 4'(BEAT_MAX - 1);

  state_t     state_q, state_d;
  logic [1:0] owner_q, owner_d;
  logic [1:0] ptr_q, ptr_d;
  logic [3:0] beat_q, beat_d;
  logic [3:0] grant_q, grant_d;

  logic       xfer;
  logic [1:0] ptr_next;
  logic [2:0] win_idle;
  logic [2:0] win_rel;

  // Returns {found, index} of the first request at or after p, wrapping mod 4.
  function automatic logic [2:0] arbitrate(input logic [3:0] r, input logic [1:0] p);
    logic [2:0] res;
    logic [1:0] idx;
    res = 3'b000;
    for (int k = 3; k >= 0; k--) begin
      idx = p + 2'(k);
      if (r[idx]) res = {1'b1, idx};
    end
    return res;
  endfunction

  assign valid    = (state_q == ST_GRANT) && req[owner_q];
  assign xfer     = valid && ready;
  assign ptr_next = owner_q + 2'd1;
  assign win_idle = arbitrate(req, ptr_q);
  assign win_rel  = arbitrate(req, ptr_next);

  always_comb begin
    state_d = state_q;
    owner_d = owner_q;
    ptr_d   = ptr_q;
    beat_d  = beat_q;
    grant_d = grant_q;
    case (state_q)
      ST_IDLE: begin
        if (win_idle[2]) begin
          state_d = ST_GRANT;
          owner_d = win_idle[1:0];
          grant_d = 4'b0001 << win_idle[1:0];
          beat_d  = 4'd0;
        end
      end
      ST_GRANT: begin
        // A dropped request and a final beat on the same edge are one release.
        if (!req[owner_q] || (xfer && beat_q == BEAT_LAST)) begin
          ptr_d  = ptr_next;
          beat_d = 4'd0;
          if (win_rel[2]) begin
            owner_d = win_rel[1:0];
            grant_d = 4'b0001 << win_rel[1:0];
          end else begin
            state_d = ST_IDLE;
            grant_d = 4'b0000;
          end
        end else if (xfer) begin
          beat_d = beat_q + 4'd1;
        end
      end
      default: begin
        state_d = ST_IDLE;
        grant_d = 4'b0000;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
      owner_q <= 2'd0;
      ptr_q   <= 2'd0;
      beat_q  <= 4'd0;
      grant_q <= 4'b0000;
    end else begin
      state_q <= state_d;
      owner_q <= owner_d;
      ptr_q   <= ptr_d;
      beat_q  <= beat_d;
      grant_q <= grant_d;
    end
  end

  assign grant = grant_q;
  assign s1    = owner_q[1];
  assign s0    = owner_q[0];

  always_comb begin
    y = a;
    case (owner_q)
      2'd0: y = a;
      2'd1: y = b;
      2'd2: y = c;
      2'd3: y = d;
      default: y = a;
    endcase
  end

endmodule

// File: tb/tb_lab_1_rr_arbiter.sv
// Self-checking bench for lab_1_rr_arbiter: directed scenarios plus random
// traffic compared against a transfer-counting round-robin model.
module tb_lab_1_rr_arbiter;
  localparam int BM = 4;

  logic       clk = 1'b0;
  logic       rst;
  logic [3:0] req;
  logic [1:0] a, b, c, d;
  logic       ready;
  logic [3:0] grant;
  logic       s1, s0, valid;
  logic [1:0] y;

  int total = 0;
  int bad   = 0;

  // model: busy flag, owner index, next-priority index, transfers this grant
  bit m_busy;
  int m_owner, m_ptr, m_cnt;

  lab_1_rr_arbiter #(.BEAT_MAX(BM)) dut (
    .clk(clk), .rst(rst), .req(req), .a(a), .b(b), .c(c), .d(d),
    .ready(ready), .grant(grant), .s1(s1), .s0(s0), .valid(valid), .y(y)
  );

  always #5 clk = ~clk;

  function automatic int pick(input logic [3:0] r, input int p);
    for (int k = 0; k < 4; k++)
      if (r[(p + k) % 4]) return (p + k) % 4;
    return -1;
  endfunction

  function automatic logic [3:0] exp_grant();
    return m_busy ? (4'b0001 << m_owner) : 4'b0000;
  endfunction

  function automatic logic exp_valid();
    return m_busy && req[m_owner];
  endfunction

  function automatic logic [1:0] exp_y();
    logic [1:0] dat [4];
    dat[0] = a; dat[1] = b; dat[2] = c; dat[3] = d;
    return dat[m_owner];
  endfunction

  // Advance the model using the inputs held across the edge, then clock.
  task automatic cycle();
    bit nb;
    int no, np, nc, w;
    bit x;
    nb = m_busy; no = m_owner; np = m_ptr; nc = m_cnt;
    if (rst) begin
      nb = 0; no = 0; np = 0; nc = 0;
    end else if (!m_busy) begin
      w = pick(req, m_ptr);
      if (w >= 0) begin nb = 1; no = w; nc = 0; end
    end else begin
      x = req[m_owner] && ready;
      if (!req[m_owner] || (x && m_cnt + 1 == BM)) begin
        np = (m_owner + 1) % 4;
        nc = 0;
        w  = pick(req, np);
        if (w >= 0) no = w;
        else nb = 0;
      end else if (x) begin
        nc = m_cnt + 1;
      end
    end
    @(posedge clk);
    m_busy = nb; m_owner = no; m_ptr = np; m_cnt = nc;
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1; req = 4'b0000; ready = 1'b0;
    cycle();
    rst = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1; req = 4'b1111; ready = 1'b0;
    a = 2'b01; b = 2'b10; c = 2'b11; d = 2'b00;
    for (int i = 0; i < 2; i++) begin
      cycle();
      #1;
      total += 4;
      if (grant !== 4'b0000) begin bad++; $display("FAIL reset_grant got=%b want=0000", grant); end
      if ({s1, s0} !== 2'b00) begin bad++; $display("FAIL reset_sel got=%b want=00", {s1, s0}); end
      if (valid !== 1'b0) begin bad++; $display("FAIL reset_valid got=%b want=0", valid); end
      if (y !== 2'b01) begin bad++; $display("FAIL reset_y got=%b want=01", y); end
    end
    rst = 1'b0;
    cycle();
    #1;
    total++;
    if (grant !== 4'b0001) begin bad++; $display("FAIL reset_release_grant got=%b want=0001", grant); end
  endtask

  task automatic test_single();
    do_reset();
    req = 4'b0100; c = 2'b10; ready = 1'b1;
    for (int i = 0; i < 12; i++) begin
      cycle();
      #1;
      total += 4;
      if (grant !== 4'b0100) begin bad++; $display("FAIL single_grant cyc=%0d got=%b want=0100", i, grant); end
      if ({s1, s0} !== 2'b10) begin bad++; $display("FAIL single_sel cyc=%0d got=%b want=10", i, {s1, s0}); end
      if (y !== 2'b10) begin bad++; $display("FAIL single_y cyc=%0d got=%b want=10", i, y); end
      if (valid !== 1'b1) begin bad++; $display("FAIL single_valid cyc=%0d got=%b want=1", i, valid); end
    end
  endtask

  task automatic test_rotation();
    logic [3:0] want;
    do_reset();
    req = 4'b1111; ready = 1'b1;
    for (int i = 0; i < 20; i++) begin
      cycle();
      #1;
      want = 4'b0001 << ((i / BM) % 4);
      total += 2;
      if (grant !== want) begin bad++; $display("FAIL rotation_grant cyc=%0d got=%b want=%b", i, grant, want); end
      if (valid !== 1'b1) begin bad++; $display("FAIL rotation_valid cyc=%0d got=%b want=1", i, valid); end
    end
  endtask

  task automatic test_backpressure();
    logic pat [7];
    int xfers;
    pat = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1};
    xfers = 0;
    do_reset();
    req = 4'b0010; ready = 1'b0;
    cycle();
    for (int i = 0; i < 7; i++) begin
      ready = pat[i];
      if (i == 6) req = 4'b1010;
      #1;
      total += 2;
      if (grant !== 4'b0010) begin bad++; $display("FAIL bp_grant cyc=%0d got=%b want=0010", i, grant); end
      if (valid !== 1'b1) begin bad++; $display("FAIL bp_valid cyc=%0d got=%b want=1", i, valid); end
      if (valid && ready) xfers++;
      cycle();
    end
    #1;
    total += 2;
    if (xfers !== 4) begin bad++; $display("FAIL bp_xfers got=%0d want=4", xfers); end
    if (grant !== 4'b1000) begin bad++; $display("FAIL bp_release got=%b want=1000", grant); end
  endtask

  task automatic test_early_drop();
    do_reset();
    req = 4'b1010; ready = 1'b1;
    a = 2'b00; b = 2'b01; c = 2'b10; d = 2'b11;
    cycle();
    for (int i = 0; i < 2; i++) begin
      #1;
      total++;
      if (grant !== 4'b0010) begin bad++; $display("FAIL drop_owner1 cyc=%0d got=%b want=0010", i, grant); end
      cycle();
    end
    // requester 0 also asks: it only loses if the pointer moved to 2
    req = 4'b1001;
    #1;
    total++;
    if (valid !== 1'b0) begin bad++; $display("FAIL drop_valid got=%b want=0", valid); end
    cycle();
    #1;
    total += 4;
    if (grant !== 4'b1000) begin bad++; $display("FAIL drop_grant got=%b want=1000", grant); end
    if ({s1, s0} !== 2'b11) begin bad++; $display("FAIL drop_sel got=%b want=11", {s1, s0}); end
    if (y !== 2'b11) begin bad++; $display("FAIL drop_y got=%b want=11", y); end
    if (valid !== 1'b1) begin bad++; $display("FAIL drop_valid3 got=%b want=1", valid); end
  endtask

  task automatic test_reset_mid();
    do_reset();
    req = 4'b0100; ready = 1'b1;
    cycle();
    req = 4'b1000;
    cycle();
    #1;
    total++;
    if (grant !== 4'b1000) begin bad++; $display("FAIL rmid_owner3 got=%b want=1000", grant); end
    cycle();
    rst = 1'b1; req = 4'b1111;
    cycle();
    #1;
    total += 2;
    if (grant !== 4'b0000) begin bad++; $display("FAIL rmid_grant got=%b want=0000", grant); end
    if (valid !== 1'b0) begin bad++; $display("FAIL rmid_valid got=%b want=0", valid); end
    rst = 1'b0; req = 4'b1110;
    cycle();
    #1;
    total++;
    if (grant !== 4'b0010) begin bad++; $display("FAIL rmid_rearb got=%b want=0010", grant); end
  endtask

  task automatic test_random();
    logic [3:0] eg;
    logic       ev;
    logic [1:0] ey;
    do_reset();
    for (int i = 0; i < 500; i++) begin
      req   = ($urandom_range(0, 3) == 0) ? 4'(req ^ (4'b0001 << $urandom_range(0, 3))) : req;
      if ($urandom_range(0, 19) == 0) req = 4'($urandom);
      ready = ($urandom_range(0, 3) != 0);
      a = 2'($urandom); b = 2'($urandom); c = 2'($urandom); d = 2'($urandom);
      rst = ($urandom_range(0, 79) == 0);
      #1;
      eg = exp_grant(); ev = exp_valid(); ey = exp_y();
      total += 4;
      if (grant !== eg) begin bad++; $display("FAIL rand_grant cyc=%0d got=%b want=%b", i, grant, eg); end
      if ({s1, s0} !== 2'(m_owner)) begin bad++; $display("FAIL rand_sel cyc=%0d got=%b want=%0d", i, {s1, s0}, m_owner); end
      if (valid !== ev) begin bad++; $display("FAIL rand_valid cyc=%0d got=%b want=%b", i, valid, ev); end
      if (y !== ey) begin bad++; $display("FAIL rand_y cyc=%0d got=%b want=%b", i, y, ey); end
      cycle();
    end
    rst = 1'b0;
  endtask

  initial begin
    rst = 1'b1; req = 4'b0000; ready = 1'b0;
    a = 2'b00; b = 2'b00; c = 2'b00; d = 2'b00;
    m_busy = 0; m_owner = 0; m_ptr = 0; m_cnt = 0;
    #2;
    test_reset();
    test_single();
    test_rotation();
    test_backpressure();
    test_early_drop();
    test_reset_mid();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
